mole_spawn_timer: RTL and testbench
===================================

Name: mole_spawn_timer

Overview:
- Parametrised successor to the fixed 1 s countdown plus "show new number" logic of the whack-a-mole game.
- Generates a periodic spawn tick at one of four user-selected speeds.
- On each tick, picks a new pseudo-random mole hole from a free-running LFSR; the new hole never equals the previous one.
- Counts down a programmed number of rounds, then reports done.
- Sits between the board switches/game FSM and the hole LEDs/hex display.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz; sets the base period.
- N_HOLES, 16: number of mole holes; power of 2, range 2..16; POS_W = clog2(N_HOLES).
- LFSR_W, 16: LFSR width; must be at least POS_W.
- SEED, 16'hACE1: LFSR reset value; nonzero; truncated to LFSR_W.
- ROUNDS_W, 8: width of the round counter.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- clear_b  in  1  reset: synchronous, active-low
- enable  in  1  1 = period counter runs; 0 = counter holds (pause)
- par_load  in  1  reload the period counter to full period immediately
- speed  in  2  period select (SW[1:0]): 0 = 2 s, 1 = 1 s, 2 = 0.5 s, 3 = 0.25 s
- start  in  1  one-cycle request to begin or restart a game
- rounds_in  in  ROUNDS_W  number of spawns for the game; sampled on start
- spawn_tick  out  1  one-cycle pulse at each spawn
- mole_pos  out  POS_W  current hole index
- mole_valid  out  1  mole_pos holds a hole generated in this game
- rounds_left  out  ROUNDS_W  spawns remaining
- busy  out  1  state == RUN
- done  out  1  state == DONE

Behaviour:
- Reset (clear_b = 0 at a rising edge) overrides every other input:
  - state = IDLE, counter = 0, lfsr = SEED
  - mole_pos = 0, mole_valid = 0, rounds_left = 0
  - spawn_tick = 0, busy = 0, done = 0
- Period P = (2*CLK_HZ) >> speed cycles. Counter width is clog2(2*CLK_HZ); all arithmetic is unsigned.
- LFSR:
  - Galois form, advances every clock cycle in every state (player timing supplies entropy).
  - If its state is ever all-zero, it reloads SEED.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with rounds_in != 0: counter <= P-1, rounds_left <= rounds_in, mole_valid <= 0, go to RUN.
  - start=1 with rounds_in == 0: go to DONE; no tick is produced.
- RUN, evaluated at each edge in this priority order:
  - start=1: restart exactly as from IDLE.
  - par_load=1: counter <= P-1; no tick this edge, even if the counter is 0.
  - enable=0: counter holds; no tick.
  - counter != 0: counter decrements by 1.
  - counter == 0 (spawn):
    - counter <= P-1 using the current speed; a speed change therefore takes effect at the next reload.
    - spawn_tick <= 1 for one cycle.
    - cand = lfsr[POS_W-1:0]; if cand == mole_pos, use cand+1 modulo N_HOLES instead.
    - mole_pos <= result; mole_valid <= 1; rounds_left <= rounds_left - 1.
    - If rounds_left was 1, go to DONE.
- Latency: the first spawn_tick is visible P cycles after the start edge, provided enable stays high with no par_load; spawns then repeat every P cycles.
- DONE:
  - done = 1; counter frozen; mole_pos and mole_valid hold their last values.
  - start restarts as from IDLE; there is no other exit.
- spawn_tick is 0 on every edge that is not a spawn.
- Reset mid-RUN aborts immediately to the reset values; no tick occurs on the reset edge.
- rounds_left never wraps, because DONE is entered when it reaches 0.

Decomposition:
- Package mole_pkg holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - speed encoding constants
  - LFSR tap constant for 16 bits: 16'hB400
  - the period function P(speed)
- Sub-module mole_lfsr (parameters LFSR_W, SEED, TAPS; ports clock, clear_b, q) implements the free-running LFSR.
- The existing hex_decoder downstream displays mole_pos; it is not instantiated inside this block.

Test Plan:
1. Reset and first spawn (CLK_HZ=8, speed=0, so P=16): start with rounds_in=3 -> busy=1; spawn_tick is high exactly 16, 32 and 48 cycles after the start edge; rounds_left steps 2, 1, 0; done=1 from the third tick onward; mole_pos never repeats consecutively.
2. Speed change mid-period: speed=3 (P=2), switched to speed=0 between ticks -> the next interval is still 2 cycles, and the interval after that is 16.
3. Pause and par_load: enable held low for 10 cycles mid-period -> the tick is delayed by exactly 10 cycles. par_load asserted on the cycle the counter is 0 -> no tick, and the next tick comes P cycles later.
4. Repeat avoidance (N_HOLES=4): force the LFSR output equal to mole_pos=3 -> the new mole_pos is 0 (wrap), not 3.
5. Edge cases:
   - start with rounds_in=0 -> DONE next cycle; spawn_tick is never asserted.
   - start while in RUN with rounds_left=5 -> rounds_left=rounds_in, mole_valid=0, counter reloaded.
6. Reset mid-RUN: clear_b=0 for 1 cycle with counter=0 -> no spawn_tick; all outputs return to reset values; the LFSR output equals SEED on the next cycle.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared encodings and helpers for the whack-a-mole spawn timer.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Speed switch encodings (SW[1:0]).
   localparam logic [1:0] SPEED_2S    = 2'd0;
   localparam logic [1:0] SPEED_1S    = 2'd1;
   localparam logic [1:0] SPEED_500MS = 2'd2;
   localparam logic [1:0] SPEED_250MS = 2'd3;

   // Galois right-shift feedback mask for a maximal-length 16-bit sequence.
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

   // Spawn period in clock cycles: 2 s at speed 0, halved per speed step.
   function automatic longint unsigned period_cycles(input longint unsigned clk_hz,
                                                     input logic [1:0]      speed);
      return (64'd2 * clk_hz) >> speed;
   endfunction

   // Maximal-length Galois feedback masks for the supported LFSR widths.
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      logic [31:0] t;
      case (w)
         2:       t = 32'h0000_0003;
         3:       t = 32'h0000_0006;
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0E08;
         13:      t = 32'h0000_1C80;
         14:      t = 32'h0000_3802;
         15:      t = 32'h0000_6000;
         default: t = 32'(LFSR_TAPS_16);
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running Galois LFSR; recovers from the all-zero lock-up state.
module mole_lfsr #(
   parameter int unsigned       LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400)
) (
   input  logic              clock,
   input  logic              clear_b,
   output logic [LFSR_W-1:0] q
);

   // Advance one step per clock in every game state.
   always_ff @(posedge clock) begin
      if (!clear_b) begin
         q <= SEED;
      end else if (q == '0) begin
         q <= SEED;
      end else begin
         q <= (q >> 1) ^ (q[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/mole_spawn_timer.sv
// Periodic mole spawner: speed-selectable tick, non-repeating random hole, round countdown.
module mole_spawn_timer
   import mole_pkg::*;
#(
   parameter int unsigned  CLK_HZ   = 50000000,
   parameter int unsigned  N_HOLES  = 16,
   parameter int unsigned  LFSR_W   = 16,
   parameter logic [31:0]  SEED     = 32'h0000_ACE1,
   parameter int unsigned  ROUNDS_W = 8,
   localparam int unsigned POS_W    = $clog2(N_HOLES)
) (
   input  logic                clock,
   input  logic                clear_b,
   input  logic                enable,
   input  logic                par_load,
   input  logic [1:0]          speed,
   input  logic                start,
   input  logic [ROUNDS_W-1:0] rounds_in,
   output logic                spawn_tick,
   output logic [POS_W-1:0]    mole_pos,
   output logic                mole_valid,
   output logic [ROUNDS_W-1:0] rounds_left,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CNT_W = $clog2(64'd2 * 64'(CLK_HZ));

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [CNT_W-1:0]   period_m1;
   logic [LFSR_W-1:0]  lfsr_q;
   logic [POS_W-1:0]   cand;
   logic [POS_W-1:0]   next_pos;

   mole_lfsr #(
      .LFSR_W (LFSR_W),
      .SEED   (LFSR_W'(SEED)),
      .TAPS   (LFSR_W'(lfsr_taps(LFSR_W)))
   ) u_lfsr (
      .clock   (clock),
      .clear_b (clear_b),
      .q       (lfsr_q)
   );

   // Only the low LFSR bits pick the hole; the rest just carry the sequence.
   if (LFSR_W > POS_W) begin : g_lfsr_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:POS_W];
   end

   // Reload value for the current speed and the next hole, bumped to avoid a repeat.
   always_comb begin
      period_m1 = CNT_W'(period_cycles(64'(CLK_HZ), speed) - 64'd1);
      cand      = lfsr_q[POS_W-1:0];
      next_pos  = (cand == mole_pos) ? cand + POS_W'(1) : cand;
   end

   // Game FSM: start wins in every state, then par_load, pause, countdown, spawn.
   always_ff @(posedge clock) begin
      if (!clear_b) begin
         state       <= IDLE;
         counter     <= '0;
         mole_pos    <= '0;
         mole_valid  <= 1'b0;
         rounds_left <= '0;
         spawn_tick  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         spawn_tick <= 1'b0;
         if (start) begin
            if (rounds_in != '0) begin
               state       <= RUN;
               counter     <= period_m1;
               rounds_left <= rounds_in;
               mole_valid  <= 1'b0;
               busy        <= 1'b1;
               done        <= 1'b0;
            end else begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE: ;
               RUN: begin
                  if (par_load) begin
                     counter <= period_m1;
                  end else if (enable) begin
                     if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                     end else begin
                        counter     <= period_m1;
                        spawn_tick  <= 1'b1;
                        mole_pos    <= next_pos;
                        mole_valid  <= 1'b1;
                        rounds_left <= rounds_left - ROUNDS_W'(1);
                        if (rounds_left == ROUNDS_W'(1)) begin
                           state <= DONE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end
                  end
               end
               DONE: ;
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mole_spawn_timer.sv
// Bench for mole_spawn_timer: directed vector table plus randomized run against a reference model.
module tb_mole_spawn_timer;

   localparam int unsigned CLK_HZ   = 8;
   localparam int unsigned N_HOLES  = 4;
   localparam int unsigned LFSR_W   = 16;
   localparam int unsigned SEED     = 32'h0000_ACE1;
   localparam int unsigned ROUNDS_W = 8;
   localparam int unsigned POS_W    = 2;

   logic                clock;
   logic                clear_b;
   logic                enable;
   logic                par_load;
   logic [1:0]          speed;
   logic                start;
   logic [ROUNDS_W-1:0] rounds_in;
   logic                spawn_tick;
   logic [POS_W-1:0]    mole_pos;
   logic                mole_valid;
   logic [ROUNDS_W-1:0] rounds_left;
   logic                busy;
   logic                done;

   mole_spawn_timer #(
      .CLK_HZ   (CLK_HZ),
      .N_HOLES  (N_HOLES),
      .LFSR_W   (LFSR_W),
      .SEED     (32'(SEED)),
      .ROUNDS_W (ROUNDS_W)
   ) dut (
      .clock       (clock),
      .clear_b     (clear_b),
      .enable      (enable),
      .par_load    (par_load),
      .speed       (speed),
      .start       (start),
      .rounds_in   (rounds_in),
      .spawn_tick  (spawn_tick),
      .mole_pos    (mole_pos),
      .mole_valid  (mole_valid),
      .rounds_left (rounds_left),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: game phase as text, counter as remaining cycles to the spawn.
   string       m_phase = "idle";
   int          m_wait  = 0;
   int unsigned m_lfsr  = SEED;
   int          m_pos   = 0;
   int          m_valid = 0;
   int          m_left  = 0;
   int          m_tick  = 0;
   int          n_avoid = 0;
   int          n_spawn = 0;

   function automatic int period(input int spd);
      return (2 * CLK_HZ) >> spd;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      int cand;
      if (!clear_b) begin
         m_phase = "idle"; m_wait = 0; m_lfsr = SEED;
         m_pos = 0; m_valid = 0; m_left = 0; m_tick = 0;
         return;
      end
      m_tick = 0;
      if (start) begin
         if (rounds_in != 0) begin
            m_phase = "run"; m_wait = period(speed) - 1;
            m_left = rounds_in; m_valid = 0;
         end else begin
            m_phase = "done";
         end
      end else if (m_phase == "run") begin
         if (par_load) m_wait = period(speed) - 1;
         else if (enable) begin
            if (m_wait > 0) m_wait--;
            else begin
               cand = m_lfsr % N_HOLES;
               if (cand == m_pos) begin
                  cand = (cand + 1) % N_HOLES;
                  n_avoid++;
               end
               n_spawn++;
               m_pos = cand; m_valid = 1; m_tick = 1;
               m_left--;
               m_wait = period(speed) - 1;
               if (m_left == 0) m_phase = "done";
            end
         end
      end
      if (m_lfsr == 0) m_lfsr = SEED;
      else m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'h0000_B400 : 32'h0);
   endtask

   task automatic model_cmp();
      chk("m_tick",  int'(spawn_tick),  m_tick);
      chk("m_pos",   int'(mole_pos),    m_pos);
      chk("m_valid", int'(mole_valid),  m_valid);
      chk("m_left",  int'(rounds_left), m_left);
      chk("m_busy",  int'(busy),        int'(m_phase == "run"));
      chk("m_done",  int'(done),        int'(m_phase == "done"));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      model_cmp();
      cyc++;
   endtask

   typedef struct {
      int n;
      bit clr; bit st; int rin; bit en; bit pl; int spd;
      int e_tick; int e_left; int e_busy; int e_done; int e_valid;
   } vec_t;

   vec_t vecs[$];

   initial begin
      clear_b = 1'b0; enable = 1'b1; par_load = 1'b0;
      speed = 2'd0; start = 1'b0; rounds_in = '0;

      //           n  clr st rin en pl spd  tick left busy done valid
      vecs.push_back('{2,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0}); // reset
      vecs.push_back('{1,  1, 1, 3, 1, 0, 0,  0, 3, 1, 0, 0}); // start 3 rounds, P=16
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 3, 1, 0, 0});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 2, 1, 0, 1}); // tick at +16
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  0, 2, 1, 0, 1});
      vecs.push_back('{14, 1, 0, 0, 1, 0, 0,  0, 2, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 1, 1, 0, 1}); // tick at +32
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 1, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 0, 0, 1, 1}); // tick at +48, done
      vecs.push_back('{5,  1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1});
      vecs.push_back('{1,  1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 1}); // start with 0 rounds
      vecs.push_back('{20, 1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1});
      vecs.push_back('{1,  1, 1, 5, 1, 0, 3,  0, 5, 1, 0, 0}); // 5 rounds, P=2
      vecs.push_back('{1,  1, 0, 0, 1, 0, 3,  0, 5, 1, 0, 0});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 3,  1, 4, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 3,  0, 4, 1, 0, 1}); // counter now 0
      vecs.push_back('{1,  1, 1, 9, 1, 0, 0,  0, 9, 1, 0, 0}); // restart beats spawn
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 9, 1, 0, 0});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 8, 1, 0, 1});
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 8, 1, 0, 1}); // counter now 0
      vecs.push_back('{1,  1, 0, 0, 1, 1, 0,  0, 8, 1, 0, 1}); // par_load suppresses tick
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 8, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 7, 1, 0, 1}); // P after par_load
      vecs.push_back('{5,  1, 0, 0, 1, 0, 0,  0, 7, 1, 0, 1});
      vecs.push_back('{10, 1, 0, 0, 0, 0, 0,  0, 7, 1, 0, 1}); // pause 10
      vecs.push_back('{10, 1, 0, 0, 1, 0, 0,  0, 7, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 6, 1, 0, 1}); // delayed by 10
      vecs.push_back('{15, 1, 0, 0, 1, 0, 3,  0, 6, 1, 0, 1}); // speed change mid-period
      vecs.push_back('{1,  1, 0, 0, 1, 0, 3,  1, 5, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  0, 5, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 4, 1, 0, 1}); // interval still 2
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 4, 1, 0, 1});
      vecs.push_back('{1,  1, 0, 0, 1, 0, 0,  1, 3, 1, 0, 1}); // then 16
      vecs.push_back('{15, 1, 0, 0, 1, 0, 0,  0, 3, 1, 0, 1}); // counter now 0
      vecs.push_back('{1,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0}); // reset mid-run
      vecs.push_back('{3,  1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0});

      foreach (vecs[i]) begin
         clear_b   = vecs[i].clr;
         start     = vecs[i].st;
         rounds_in = ROUNDS_W'(vecs[i].rin);
         enable    = vecs[i].en;
         par_load  = vecs[i].pl;
         speed     = 2'(vecs[i].spd);
         for (int k = 0; k < vecs[i].n; k++) begin
            step();
            start = 1'b0;
         end
         chk($sformatf("v%0d_tick",  i), int'(spawn_tick),  vecs[i].e_tick);
         chk($sformatf("v%0d_left",  i), int'(rounds_left), vecs[i].e_left);
         chk($sformatf("v%0d_busy",  i), int'(busy),        vecs[i].e_busy);
         chk($sformatf("v%0d_done",  i), int'(done),        vecs[i].e_done);
         chk($sformatf("v%0d_valid", i), int'(mole_valid),  vecs[i].e_valid);
      end

      // Randomized play against the model.
      clear_b = 1'b1; start = 1'b0; par_load = 1'b0; enable = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         clear_b   = ($urandom_range(0, 299) != 0);
         start     = ($urandom_range(0, 59) == 0);
         rounds_in = ROUNDS_W'($urandom_range(0, 6));
         enable    = ($urandom_range(0, 9) != 0);
         par_load  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
         if (k % 500 == 0) start = 1'b1;
         step();
      end

      chk("spawns_seen",  int'(n_spawn > 20), 1);
      chk("repeat_avoid", int'(n_avoid > 0),  1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
